// File: rtl/i2c_eeprom_seq.sv
// Two-requester EEPROM sequencer: arbitrates byte-write / random-read commands,
// drives an I2C master command word and waits out the EEPROM write cycle.
module i2c_eeprom_seq #(
  parameter int unsigned TWR_CYCLES     = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic [6:0]  cfg_dev_addr,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] i2c_data0,
  output logic [31:0] i2c_data1,
  input  logic [31:0] i2c_data2,
  output logic        i2c_start,
  input  logic        i2c_busy
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] TWR_LAST = CNT_W'(TWR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    TWR       = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_grant, w_grant_nxt;
  logic               r_rw, w_rw_nxt;
  logic [1:0]         r_req_ready, w_req_ready_nxt;
  logic [1:0]         r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0]         r_rsp_rdata, w_rsp_rdata_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;
  logic [31:0]        r_data0, w_data0_nxt;
  logic [31:0]        r_data1, w_data1_nxt;
  logic               r_start, w_start_nxt;

  logic               w_pick;
  logic               w_sel_rw;
  logic [7:0]         w_sel_addr;
  logic [7:0]         w_sel_wdata;
  logic [1:0]         w_pick_oh;
  logic [1:0]         w_grant_oh;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_unused_rdata_hi;

  // Round-robin: on a tie the requester not granted last wins.
  assign w_pick      = (req_valid == 2'b11) ? ~r_grant : req_valid[1];
  assign w_sel_rw    = req_rw[w_pick];
  assign w_sel_addr  = w_pick ? req_addr[15:8]  : req_addr[7:0];
  assign w_sel_wdata = w_pick ? req_wdata[15:8] : req_wdata[7:0];
  assign w_pick_oh   = w_pick  ? 2'b10 : 2'b01;
  assign w_grant_oh  = r_grant ? 2'b10 : 2'b01;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_unused_rdata_hi = ^i2c_data2[31:8];

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_grant_nxt     = r_grant;
    w_rw_nxt        = r_rw;
    w_req_ready_nxt = 2'b00;
    w_rsp_valid_nxt = 2'b00;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_data0_nxt     = r_data0;
    w_data1_nxt     = r_data1;
    w_start_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if ((req_valid != 2'b00) && !i2c_busy) begin
          w_grant_nxt     = w_pick;
          w_rw_nxt        = w_sel_rw;
          w_req_ready_nxt = w_pick_oh;
          w_data0_nxt     = {14'h0, 1'b0, w_sel_rw, w_sel_addr, cfg_dev_addr, w_sel_rw};
          w_data1_nxt     = {24'h0, w_sel_wdata};
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = 8'h00;
          w_start_nxt     = 1'b1;
          w_state_nxt     = START;
        end
      end
      START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i2c_busy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == TMO_LAST) begin
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = w_grant_oh;
          w_state_nxt     = RESP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!i2c_busy) begin
          if (r_rw) begin
            w_rsp_rdata_nxt = i2c_data2[7:0];
            w_rsp_valid_nxt = w_grant_oh;
            w_state_nxt     = RESP;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = TWR;
          end
        end else if (r_cnt == TMO_LAST) begin
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = w_grant_oh;
          w_state_nxt     = RESP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      TWR: begin
        if (r_cnt == TWR_LAST) begin
          w_rsp_valid_nxt = w_grant_oh;
          w_state_nxt     = RESP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_grant     <= 1'b1;
      r_rw        <= 1'b0;
      r_req_ready <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_data0     <= 32'h0;
      r_data1     <= 32'h0;
      r_start     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_grant     <= w_grant_nxt;
      r_rw        <= w_rw_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_data0     <= w_data0_nxt;
      r_data1     <= w_data1_nxt;
      r_start     <= w_start_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign i2c_data0 = r_data0;
  assign i2c_data1 = r_data1;
  assign i2c_start = r_start;

endmodule

// File: doc/i2c_eeprom_seq.md
I2C_EEPROM_SEQ -- requirements
Module: i2c_eeprom_seq

Interface
- REQ-001: Clocking SHALL be one clock; reset is synchronous and active-high.
- REQ-002: Parameter TWR_CYCLES, default 500000, SHALL set the EEPROM write-cycle wait in clocks (5 ms at 100 MHz).
- REQ-003: Parameter TIMEOUT_CYCLES, default 1000000, SHALL set the per-phase busy timeout in clocks.
- REQ-004: s_axi_aclk  in  1  SHALL be the clock.
- REQ-005: s_axi_areset  in  1  SHALL be the synchronous active-high reset.
- REQ-006: cfg_dev_addr  in  7  SHALL be the 7-bit device address (0x50 for AT24C02).
- REQ-007: req_valid  in  2  SHALL be the per-requester command-valid flags (bit n = requester n).
- REQ-008: req_rw  in  2  SHALL select the operation per requester: 0 = write, 1 = random read.
- REQ-009: req_addr  in  16  SHALL carry the memory addresses; [7:0] is requester 0, [15:8] is requester 1.
- REQ-010: req_wdata  in  16  SHALL carry the write bytes; [7:0] is requester 0, [15:8] is requester 1.
- REQ-011: req_ready  out  2  SHALL be a one-cycle accept pulse to the granted requester.
- REQ-012: rsp_valid  out  2  SHALL be a one-cycle completion pulse to the granted requester.
- REQ-013: rsp_rdata  out  8  SHALL return the read byte, valid with rsp_valid.
- REQ-014: rsp_err  out  1  SHALL flag a timeout, valid with rsp_valid.
- REQ-015: i2c_data0  out  32  SHALL be the master command word.
- REQ-016: i2c_data1  out  32  SHALL be the master write data.
- REQ-017: i2c_data2  in  32  SHALL be the master read data.
- REQ-018: i2c_start  out  1  SHALL be the master start pulse.
- REQ-019: i2c_busy  in  1  SHALL be the master busy flag.

Function
- REQ-020: The FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE, TWR and RESP.
- REQ-021: In IDLE, when any req_valid bit is set and i2c_busy=0, the block SHALL grant one requester, pulse its req_ready bit for exactly one cycle, latch rw/addr/wdata, and go to START.
- REQ-022: Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins.
- REQ-023: While i2c_busy=1, the block SHALL stay in IDLE and grant no requester.
- REQ-024: A requester that drops req_valid before it is granted SHALL NOT be served.
- REQ-025: i2c_data0 SHALL equal {14'h0, 1'b0, rw, addr[7:0], cfg_dev_addr, rw}, driven from latched values.
- REQ-026: i2c_data1 SHALL equal {24'h0, wdata}.
- REQ-027: i2c_data0 and i2c_data1 SHALL hold stable from START until return to IDLE.
- REQ-028: In START, i2c_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_BUSY.
- REQ-029: In WAIT_BUSY, i2c_busy=1 SHALL move the FSM to WAIT_DONE.
- REQ-030: In WAIT_DONE, i2c_busy=0 SHALL move the FSM to TWR for a write, or to RESP for a read.
- REQ-031: On the read exit from WAIT_DONE, the block SHALL capture rsp_rdata <= i2c_data2[7:0].
- REQ-032: A timeout counter SHALL clear on entry to WAIT_BUSY and to WAIT_DONE.
- REQ-033: When the timeout counter reaches TIMEOUT_CYCLES-1 in either state, the block SHALL set the error flag and go to RESP, skipping TWR.
- REQ-034: TWR SHALL last exactly TWR_CYCLES cycles, then go to RESP.
- REQ-035: In RESP, rsp_valid[grant] and rsp_err SHALL be valid for one cycle, then the FSM SHALL return to IDLE.
- REQ-036: rsp_valid SHALL have no backpressure.
- REQ-037: For a write response, rsp_rdata SHALL be 0.
- REQ-038: The error flag SHALL clear on each new grant.
- REQ-039: At most one command SHALL be outstanding at any time.
- REQ-040: The earliest IDLE re-grant SHALL be the cycle after RESP.
- REQ-041: Counters SHALL be 32-bit and SHALL NOT wrap: each clears on state entry.

Reset
- REQ-042: While s_axi_areset=1 at a clock edge, the outputs SHALL be: all outputs 0, i2c_data0 = 0, i2c_data1 = 0.
- REQ-043: During reset, the FSM SHALL return to IDLE and the round-robin pointer SHALL be set so that requester 0 wins the first tie.
- REQ-044: Reset mid-operation SHALL abort with no rsp_valid or i2c_start issued afterwards.

Verification
- REQ-045: Write scenario: req0 write addr 0x10, wdata 0xA5, cfg 0x50 -> req_ready=01 for 1 cycle; i2c_data0=0x000010A0; i2c_data1=0xA5; one i2c_start pulse; after master busy 1->0, exactly TWR_CYCLES cycles then rsp_valid=01, rsp_err=0.
- REQ-046: Read scenario: req1 read addr 0x3C, master returns i2c_data2=0x5A -> i2c_data0=0x00013CA1; rsp_valid=10, rsp_rdata=0x5A, no TWR wait.
- REQ-047: Arbitration scenario: both valid from reset and held -> grants alternate 0,1,0,1, each completing before the next req_ready.
- REQ-048: Timeout scenario: i2c_busy never rises (TIMEOUT_CYCLES=16) -> rsp_valid after 16 WAIT_BUSY cycles, rsp_err=1; the next command has rsp_err=0.
- REQ-049: Reset-abort scenario: reset asserted in WAIT_DONE and TWR -> outputs 0 next cycle; no rsp_valid; a new command after reset proceeds normally.
- REQ-050: Busy-gate scenario: i2c_busy=1 in IDLE with req0 valid -> no req_ready until busy=0.
